// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver: input conditioning, framed byte capture with parity/stop/timeout
// checking, and E0/F0-aware decoding of make-codes into direction/start/pause events.
module ps2_direction_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic [1:0] dir_out,
  output logic       dir_valid,
  output logic       start_pulse,
  output logic       pause_pulse,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip, fall_evt;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          good_d, bad_d;

  logic          ext, brk;
  logic          map_hit, map_start, map_pause;
  logic [1:0]    map_dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Counter tracks how long the synchronized clock has disagreed with the filtered level;
  // the FILTER_LEN-th disagreeing sample flips the filter.
  assign filt_flip = (clk_s2 != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall_evt  = filt_flip && clk_filt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    if (state_q == IDLE) tmo_d = '0;
    if (fall_evt) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_s2) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        DATA: begin
          shift_d   = {data_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s2;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (((^shift_q) ^ par_q) && data_s2) good_d = 1'b1;
          else                                 bad_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A fall_evt in the same cycle takes the branch above, so it always beats the timeout.
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = '0;
        state_d = IDLE;
        bad_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= good_d;
      frame_err <= bad_d;
      if (good_d) key_code <= shift_q;
    end
  end

  always_comb begin
    map_hit   = 1'b0;
    map_dir   = 2'b00;
    map_start = 1'b0;
    map_pause = 1'b0;
    if (ext) begin
      case (key_code)
        8'h75: begin map_hit = 1'b1; map_dir = 2'b00; end
        8'h72: begin map_hit = 1'b1; map_dir = 2'b01; end
        8'h6B: begin map_hit = 1'b1; map_dir = 2'b10; end
        8'h74: begin map_hit = 1'b1; map_dir = 2'b11; end
        default: ;
      endcase
    end else begin
      case (key_code)
        8'h1D: begin map_hit = 1'b1; map_dir = 2'b00; end
        8'h1B: begin map_hit = 1'b1; map_dir = 2'b01; end
        8'h1C: begin map_hit = 1'b1; map_dir = 2'b10; end
        8'h23: begin map_hit = 1'b1; map_dir = 2'b11; end
        8'h29: map_start = 1'b1;
        8'h4D: map_pause = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      dir_out     <= 2'b11;
      dir_valid   <= 1'b0;
      start_pulse <= 1'b0;
      pause_pulse <= 1'b0;
    end else begin
      dir_valid   <= 1'b0;
      start_pulse <= 1'b0;
      pause_pulse <= 1'b0;
      if (key_valid) begin
        if (key_code == 8'hE0) begin
          ext <= 1'b1;
        end else if (key_code == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk) begin
            if (map_hit) begin
              dir_out   <= map_dir;
              dir_valid <= 1'b1;
            end
            start_pulse <= map_start;
            pause_pulse <= map_pause;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: expected output events are queued by the stimulus
// and a negedge monitor pops and compares each pulse the DUT produces.
module tb_ps2_direction_decoder;

  localparam int unsigned FLEN = 4;
  localparam int unsigned TMO  = 300;
  localparam int unsigned HALF = 20;

  localparam int K_KEY = 0, K_DIR = 1, K_START = 2, K_PAUSE = 3, K_ERR = 4;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } evt_t;

  logic       clk, reset_n, ps2_clk, ps2_data;
  logic [7:0] key_code;
  logic       key_valid, dir_valid, start_pulse, pause_pulse, frame_err;
  logic [1:0] dir_out;

  evt_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_key_cyc = -10;

  ps2_direction_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_valid(key_valid), .dir_out(dir_out), .dir_valid(dir_valid),
    .start_pulse(start_pulse), .pause_pulse(pause_pulse), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [7:0] val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input string name, input int kind, input logic [7:0] val);
    evt_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event kind=%0d val=%02h, required none", name, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d val=%02h, required kind=%0d val=%02h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic check_lag(input string name);
    n_tests++;
    if (cyc != last_key_cyc + 1) begin
      n_fail++;
      $display("FAIL %s_lag: event at cycle %0d, required %0d", name, cyc, last_key_cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (frame_err) check_evt("frame_err", K_ERR, 8'h00);
      if (key_valid) begin
        check_evt("key", K_KEY, key_code);
        last_key_cyc = cyc;
      end
      if (dir_valid) begin
        check_evt("dir", K_DIR, {6'b0, dir_out});
        check_lag("dir");
      end
      if (start_pulse) begin
        check_evt("start", K_START, 8'h00);
        check_lag("start");
      end
      if (pause_pulse) begin
        check_evt("pause", K_PAUSE, 8'h00);
        check_lag("pause");
      end
    end
  end

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (HALF / 2) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_ok ? ~(^b) : (^b));
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (3 * HALF) @(posedge clk);
  endtask

  task automatic check_dir(input string name, input logic [1:0] req);
    @(negedge clk);
    check_eq(name, {6'b0, dir_out}, {6'b0, req});
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_key_code", key_code, 8'h00);
    check_eq("rst_dir_out", {6'b0, dir_out}, 8'h03);
    check_eq("rst_pulses", {3'b0, key_valid, dir_valid, start_pulse, pause_pulse, frame_err}, 8'h00);
    @(posedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);

    // single make-code
    push(K_KEY, 8'h1D); push(K_DIR, 8'h00);
    send_frame(8'h1D, 1'b1, 1'b1);
    check_dir("dir_after_1D", 2'b00);

    // extended codes
    push(K_KEY, 8'hE0);
    send_frame(8'hE0, 1'b1, 1'b1);
    push(K_KEY, 8'h75); push(K_DIR, 8'h00);
    send_frame(8'h75, 1'b1, 1'b1);
    push(K_KEY, 8'hE0);
    send_frame(8'hE0, 1'b1, 1'b1);
    push(K_KEY, 8'h6B); push(K_DIR, 8'h02);
    send_frame(8'h6B, 1'b1, 1'b1);
    check_dir("dir_after_E06B", 2'b10);
    push(K_KEY, 8'h23); push(K_DIR, 8'h03);
    send_frame(8'h23, 1'b1, 1'b1);

    // break sequences
    push(K_KEY, 8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1);
    push(K_KEY, 8'h1C);
    send_frame(8'h1C, 1'b1, 1'b1);
    check_dir("dir_after_break", 2'b11);
    push(K_KEY, 8'h1C); push(K_DIR, 8'h02);
    send_frame(8'h1C, 1'b1, 1'b1);
    check_dir("dir_after_1C", 2'b10);
    push(K_KEY, 8'hE0);
    send_frame(8'hE0, 1'b1, 1'b1);
    push(K_KEY, 8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1);
    push(K_KEY, 8'h75);
    send_frame(8'h75, 1'b1, 1'b1);
    push(K_KEY, 8'h1D); push(K_DIR, 8'h00);
    send_frame(8'h1D, 1'b1, 1'b1);
    check_dir("dir_flags_cleared", 2'b00);

    // framing errors
    push(K_ERR, 8'h00);
    send_frame(8'h23, 1'b0, 1'b1);
    check_dir("dir_after_parity_err", 2'b00);
    push(K_ERR, 8'h00);
    send_frame(8'h29, 1'b1, 1'b0);

    // timeout and recovery
    push(K_ERR, 8'h00);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TMO + 100) @(posedge clk);
    push(K_KEY, 8'h29); push(K_START, 8'h00);
    send_frame(8'h29, 1'b1, 1'b1);
    push(K_KEY, 8'h4D); push(K_PAUSE, 8'h00);
    send_frame(8'h4D, 1'b1, 1'b1);

    // short low glitch in IDLE must not start a frame
    ps2_data = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (FLEN - 2) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(posedge clk);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    push(K_KEY, 8'h1C); push(K_DIR, 8'h02);
    send_frame(8'h1C, 1'b1, 1'b1);
    check_dir("dir_after_glitch", 2'b10);

    // reset in the middle of a frame
    send_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_key_code", key_code, 8'h00);
    check_eq("midrst_dir_out", {6'b0, dir_out}, 8'h03);
    check_eq("midrst_pulses", {3'b0, key_valid, dir_valid, start_pulse, pause_pulse, frame_err}, 8'h00);
    @(posedge clk);
    reset_n  = 1'b1;
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    push(K_KEY, 8'h1B); push(K_DIR, 8'h01);
    send_frame(8'h1B, 1'b1, 1'b1);
    check_dir("dir_after_reset_1B", 2'b01);

    repeat (50) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
